// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: fetch FSM states, reset PC default
// and the mask that forces fetch addresses onto a word boundary.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Wide enough for any PC width up to 64; callers truncate to ADDR_W.
  localparam logic [63:0] WORD_ALIGN_MASK = ~64'h3;

endpackage

// File: rtl/ALU_suma.sv
// Plain adder; the fetch path uses it as PC+4 outside the fetch controller.
module ALU_suma #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  // Modulo-2^W sum, carry out intentionally dropped.
  assign y = a + b;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, issues one memory request at a
// time, buffers the returned word and handles branch redirects in flight.
module pc_fetch_ctrl
  import riscv_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] PC_reg_out,
  input  logic [ADDR_W-1:0] Next_PC,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [ADDR_W-1:0] imem_rdata_i,
  output logic              instr_valid_o,
  output logic [ADDR_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  input  logic              instr_ready_i
);

  localparam logic [ADDR_W-1:0] ALIGN = ADDR_W'(WORD_ALIGN_MASK);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              drop_q, drop_d;

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ipc_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state, PC update, instruction capture and stale-beat tracking.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        // A redirect coinciding with a grant cannot retract the accepted
        // request, so its response is marked stale and waited out.
        if (imem_gnt_i) begin
          state_d = WAIT;
          drop_d  = branch_taken_i;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          if (drop_q || branch_taken_i) begin
            state_d = REQ;
            drop_d  = 1'b0;
          end else begin
            instr_d = imem_rdata_i;
            ipc_d   = pc_q;
            state_d = OUT;
          end
        end else if (branch_taken_i) begin
          drop_d = 1'b1;
        end
      end
      OUT: begin
        if (branch_taken_i || instr_ready_i) state_d = REQ;
        if (instr_ready_i && !branch_taken_i) pc_d = Next_PC;
      end
      default: state_d = IDLE;
    endcase
    // Redirect has priority over sequential advance in every active state.
    if (branch_taken_i && state_q != IDLE) pc_d = branch_target_i & ALIGN;
  end

  assign PC_reg_out    = pc_q;
  assign imem_req_o    = (state_q == REQ);
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = (state_q == OUT);
  assign instr_o       = instr_q;
  assign instr_pc_o    = ipc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with the PC+4 adder alongside.
module tb_pc_fetch_ctrl;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] PC_reg_out, Next_PC;
  logic          branch_taken_i;
  logic [AW-1:0] branch_target_i;
  logic          imem_req_o;
  logic [AW-1:0] imem_addr_o;
  logic          imem_gnt_i, imem_rvalid_i;
  logic [AW-1:0] imem_rdata_i;
  logic          instr_valid_o;
  logic [AW-1:0] instr_o, instr_pc_o;
  logic          instr_ready_i;
  logic [AW-1:0] four = 32'd4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ALU_suma #(.W(AW)) u_add (.a(PC_reg_out), .b(four), .y(Next_PC));

  pc_fetch_ctrl #(.ADDR_W(AW), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .PC_reg_out(PC_reg_out), .Next_PC(Next_PC),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o),
    .instr_pc_o(instr_pc_o), .instr_ready_i(instr_ready_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [AW-1:0] obs,
                     input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    branch_taken_i = 1'b0; branch_target_i = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    instr_ready_i = 1'b0;
    tick(); tick();
    chk("rst_pc", PC_reg_out, 32'h0);
    chk("rst_req", {31'b0, imem_req_o}, 32'h0);
    chk("rst_valid", {31'b0, instr_valid_o}, 32'h0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_ipc", instr_pc_o, 32'h0);

    // Reset fetch
    rst_n = 1'b1;
    tick();
    chk("f0_req", {31'b0, imem_req_o}, 32'h1);
    chk("f0_addr", imem_addr_o, 32'h0);
    imem_gnt_i = 1'b1;
    tick(); imem_gnt_i = 1'b0;
    chk("f0_wait_req", {31'b0, imem_req_o}, 32'h0);
    tick();
    chk("f0_wait_valid", {31'b0, instr_valid_o}, 32'h0);
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0013;
    tick(); imem_rvalid_i = 1'b0; imem_rdata_i = 32'hBAD0_BAD0;
    chk("f0_valid", {31'b0, instr_valid_o}, 32'h1);
    chk("f0_instr", instr_o, 32'h13);
    chk("f0_ipc", instr_pc_o, 32'h0);

    // Backpressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {31'b0, instr_valid_o}, 32'h1);
      chk("bp_instr", instr_o, 32'h13);
      chk("bp_req", {31'b0, imem_req_o}, 32'h0);
    end
    instr_ready_i = 1'b1;
    tick(); instr_ready_i = 1'b0;
    chk("f1_req", {31'b0, imem_req_o}, 32'h1);
    chk("f1_addr", imem_addr_o, 32'h4);
    chk("f1_valid", {31'b0, instr_valid_o}, 32'h0);

    // Redirect in WAIT
    imem_gnt_i = 1'b1;
    tick(); imem_gnt_i = 1'b0;
    branch_taken_i = 1'b1; branch_target_i = 32'h0000_0102;
    tick(); branch_taken_i = 1'b0;
    chk("rw_pc", PC_reg_out, 32'h100);
    chk("rw_req", {31'b0, imem_req_o}, 32'h0);
    chk("rw_valid", {31'b0, instr_valid_o}, 32'h0);
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    tick(); imem_rvalid_i = 1'b0;
    chk("rw_drop_valid", {31'b0, instr_valid_o}, 32'h0);
    chk("rw_req2", {31'b0, imem_req_o}, 32'h1);
    chk("rw_addr", imem_addr_o, 32'h100);

    // Handshake and redirect together in OUT
    imem_gnt_i = 1'b1;
    tick(); imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0050_0093;
    tick(); imem_rvalid_i = 1'b0;
    chk("ro_instr", instr_o, 32'h0050_0093);
    chk("ro_ipc", instr_pc_o, 32'h100);
    instr_ready_i = 1'b1; branch_taken_i = 1'b1; branch_target_i = 32'h200;
    tick(); instr_ready_i = 1'b0; branch_taken_i = 1'b0;
    chk("ro_pc", PC_reg_out, 32'h200);
    chk("ro_valid", {31'b0, instr_valid_o}, 32'h0);
    chk("ro_addr", imem_addr_o, 32'h200);

    // Redirect in REQ (unaligned target) then wrap
    branch_taken_i = 1'b1; branch_target_i = 32'hFFFF_FFFF;
    tick(); branch_taken_i = 1'b0;
    chk("rq_req", {31'b0, imem_req_o}, 32'h1);
    chk("rq_addr", imem_addr_o, 32'hFFFF_FFFC);
    imem_gnt_i = 1'b1;
    tick(); imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0073;
    tick(); imem_rvalid_i = 1'b0;
    chk("wr_ipc", instr_pc_o, 32'hFFFF_FFFC);
    instr_ready_i = 1'b1;
    tick(); instr_ready_i = 1'b0;
    chk("wr_addr", imem_addr_o, 32'h0);

    // rvalid outside WAIT is ignored
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1111_1111;
    tick(); imem_rvalid_i = 1'b0;
    chk("ign_req", {31'b0, imem_req_o}, 32'h1);
    chk("ign_valid", {31'b0, instr_valid_o}, 32'h0);
    chk("ign_instr", instr_o, 32'h0000_0073);

    // Fetch at 0, advance to 4, then reset while waiting
    imem_gnt_i = 1'b1;
    tick(); imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_00B3;
    tick(); imem_rvalid_i = 1'b0;
    instr_ready_i = 1'b1;
    tick(); instr_ready_i = 1'b0;
    chk("pr_addr", imem_addr_o, 32'h4);
    imem_gnt_i = 1'b1;
    tick(); imem_gnt_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_pc", PC_reg_out, 32'h0);
    chk("ar_req", {31'b0, imem_req_o}, 32'h0);
    chk("ar_valid", {31'b0, instr_valid_o}, 32'h0);
    chk("ar_instr", instr_o, 32'h0);
    chk("ar_ipc", instr_pc_o, 32'h0);
    tick();
    rst_n = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h2222_2222;
    tick(); imem_rvalid_i = 1'b0;
    chk("ar_late_valid", {31'b0, instr_valid_o}, 32'h0);
    chk("ar_late_req", {31'b0, imem_req_o}, 32'h1);
    chk("ar_late_addr", imem_addr_o, 32'h0);
    imem_gnt_i = 1'b1;
    tick(); imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0033;
    tick(); imem_rvalid_i = 1'b0;
    chk("ar_f_instr", instr_o, 32'h33);
    chk("ar_f_ipc", instr_pc_o, 32'h0);
    chk("ar_f_valid", {31'b0, instr_valid_o}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
